// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, control-word
// bit positions and the one-hot T-state encoding.
package sap1_pkg;

  localparam int T_COUNT = 6;
  localparam int CTRL_W  = 12;

  // Upper nibble of the instruction register
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bit positions inside the control word {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam int CTRL_CP = 11;
  localparam int CTRL_EP = 10;
  localparam int CTRL_LM = 9;
  localparam int CTRL_CE = 8;
  localparam int CTRL_LI = 7;
  localparam int CTRL_EI = 6;
  localparam int CTRL_LA = 5;
  localparam int CTRL_EA = 4;
  localparam int CTRL_SU = 3;
  localparam int CTRL_EU = 2;
  localparam int CTRL_LB = 1;
  localparam int CTRL_LO = 0;

  // One-hot ring states; all-zero is the post-reset idle state
  typedef enum logic [T_COUNT-1:0] {
    T_IDLE = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } t_state_e;

  // Control word with a single bit set at the given position
  function automatic logic [CTRL_W-1:0] cbit(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Idle/one-hot T-state ring. Leaves idle on the first enabled edge, then
// rotates T1..T6 while run is high; freeze parks it in place (halt).
module sap1_ring_counter
  import sap1_pkg::*;
#(
  parameter int NUM_T = T_COUNT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     run,
  input  logic     freeze,
  output t_state_e t_state
);

  t_state_e           state_reg;
  logic [T_COUNT-1:0] rot;

  // Rotate-left by one position: T6 wraps back to T1
  for (genvar gi = 0; gi < NUM_T; gi++) begin : g_rot
    assign rot[gi] = state_reg[(gi + NUM_T - 1) % NUM_T];
  end

  // Step the ring; run low or freeze high holds the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= T_IDLE;
    end else if (run) begin
      if (state_reg == T_IDLE) begin
        state_reg <= T1;
      end else if (!freeze) begin
        state_reg <= t_state_e'(rot);
      end
    end
  end

  assign t_state = state_reg;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: T-state ring plus combinational decode of the
// current T-state and IR opcode into the 12-bit bus control word.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int NUM_T = T_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [3:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic [NUM_T-1:0]  t_state,
  output logic              halted,
  output logic              instr_done
);

  t_state_e          ring_state;
  logic              halted_reg;
  logic              halt_now;
  logic [CTRL_W-1:0] ctrl_next;

  // HLT in T4: the ring must not leave T4 on this edge
  assign halt_now = (ring_state == T4) && (opcode == OP_HLT);

  sap1_ring_counter #(
    .NUM_T (NUM_T)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .freeze  (halted_reg | halt_now),
    .t_state (ring_state)
  );

  // Sticky halt flag, set on the edge that ends T4 of HLT; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_reg <= 1'b0;
    end else if (run && halt_now) begin
      halted_reg <= 1'b1;
    end
  end

  // Microcode decode; kept combinational because the IR loads on the edge entering T4
  always_comb begin
    ctrl_next = '0;
    if (run && !halted_reg) begin
      case (ring_state)
        T1: ctrl_next = cbit(CTRL_EP) | cbit(CTRL_LM);
        T2: ctrl_next = cbit(CTRL_CP);
        T3: ctrl_next = cbit(CTRL_CE) | cbit(CTRL_LI);
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: ctrl_next = cbit(CTRL_EI) | cbit(CTRL_LM);
            OP_OUT:                 ctrl_next = cbit(CTRL_EA) | cbit(CTRL_LO);
            default:                ctrl_next = '0;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         ctrl_next = cbit(CTRL_CE) | cbit(CTRL_LA);
            OP_ADD, OP_SUB: ctrl_next = cbit(CTRL_CE) | cbit(CTRL_LB);
            default:        ctrl_next = '0;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  ctrl_next = cbit(CTRL_EU) | cbit(CTRL_LA);
            OP_SUB:  ctrl_next = cbit(CTRL_EU) | cbit(CTRL_LA) | cbit(CTRL_SU);
            default: ctrl_next = '0;
          endcase
        end
        default: ctrl_next = '0;
      endcase
    end
  end

  assign ctrl       = ctrl_next;
  assign t_state    = ring_state;
  assign halted     = halted_reg;
  assign instr_done = run && !halted_reg && (ring_state == T6);

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for the SAP-1 control sequencer.
module tb_sap1_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  opcode;
  logic [11:0] ctrl;
  logic [5:0]  t_state;
  logic        halted;
  logic        instr_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sap1_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .ctrl       (ctrl),
    .t_state    (t_state),
    .halted     (halted),
    .instr_done (instr_done)
  );

  // At most one bus driver (Ep, Ce, Ei, Ea, Eu) in any cycle
  always @(negedge clk) begin
    logic [4:0] drv;
    drv = {ctrl[10], ctrl[8], ctrl[6], ctrl[4], ctrl[2]};
    n_assert++;
    if (!$onehot0(drv)) begin
      n_fail++;
      $display("FAIL bus_onehot t=%0t ctrl=%h drivers=%b required at most one set", $time, ctrl, drv);
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    run    = 1'b0;
    opcode = 4'b0000;
    repeat (2) @(negedge clk);
    n_assert++; if (t_state !== 6'b000000) begin n_fail++; $display("FAIL reset_t_state got %b expected 000000", t_state); end
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL reset_ctrl got %h expected 000", ctrl); end
    n_assert++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b expected 0", halted); end
    n_assert++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_instr_done got %b expected 0", instr_done); end
    run = 1'b1;
    @(negedge clk);
    n_assert++; if (t_state !== 6'b000000) begin n_fail++; $display("FAIL reset_run_t_state got %b expected 000000", t_state); end
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL reset_run_ctrl got %h expected 000", ctrl); end
    // released with run low: must stay idle
    run   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++; if (t_state !== 6'b000000) begin n_fail++; $display("FAIL idle_norun_t_state got %b expected 000000", t_state); end
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL idle_norun_ctrl got %h expected 000", ctrl); end
    run = 1'b1;
    $display("test_reset done");
  endtask

  // T1..T3; junk opcode in T1/T2 must not matter, real opcode presented for T4
  task automatic test_fetch(input logic [3:0] op);
    logic [5:0]  exp_t [3] = '{6'b000001, 6'b000010, 6'b000100};
    logic [11:0] exp_c [3] = '{12'h600, 12'h800, 12'h180};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++; if (t_state !== exp_t[i]) begin n_fail++; $display("FAIL fetch_t_state op=%b step %0d got %b expected %b", op, i, t_state, exp_t[i]); end
      n_assert++; if (ctrl !== exp_c[i]) begin n_fail++; $display("FAIL fetch_ctrl op=%b step %0d got %h expected %h", op, i, ctrl, exp_c[i]); end
      if (i == 0) opcode = 4'b1111;
    end
    n_assert++; if (halted !== 1'b0) begin n_fail++; $display("FAIL fetch_halted op=%b got %b expected 0", op, halted); end
    opcode = op;
    $display("fetch op=%b done", op);
  endtask

  task automatic test_lda();
    logic [11:0] exp_c [3] = '{12'h240, 12'h120, 12'h000};
    test_fetch(4'b0000);
    for (int i = 0; i < 3; i++) begin
      logic [5:0] exp_t;
      exp_t = 6'b001000 << i;
      @(negedge clk);
      n_assert++; if (t_state !== exp_t) begin n_fail++; $display("FAIL lda_t_state step %0d got %b expected %b", i, t_state, exp_t); end
      n_assert++; if (ctrl !== exp_c[i]) begin n_fail++; $display("FAIL lda_ctrl step %0d got %h expected %h", i, ctrl, exp_c[i]); end
      n_assert++; if (instr_done !== (i == 2)) begin n_fail++; $display("FAIL lda_instr_done step %0d got %b expected %b", i, instr_done, (i == 2)); end
    end
    $display("test_lda done");
  endtask

  task automatic test_add_sub();
    logic [11:0] exp_c [3];
    for (int k = 0; k < 2; k++) begin
      exp_c = '{12'h240, 12'h102, (k == 0) ? 12'h024 : 12'h02C};
      test_fetch((k == 0) ? 4'b0001 : 4'b0010);
      for (int i = 0; i < 3; i++) begin
        logic [5:0] exp_t;
        exp_t = 6'b001000 << i;
        @(negedge clk);
        n_assert++; if (t_state !== exp_t) begin n_fail++; $display("FAIL addsub_t_state k=%0d step %0d got %b expected %b", k, i, t_state, exp_t); end
        n_assert++; if (ctrl !== exp_c[i]) begin n_fail++; $display("FAIL addsub_ctrl k=%0d step %0d got %h expected %h", k, i, ctrl, exp_c[i]); end
        n_assert++; if (instr_done !== (i == 2)) begin n_fail++; $display("FAIL addsub_instr_done k=%0d step %0d got %b expected %b", k, i, instr_done, (i == 2)); end
      end
      $display("test_add_sub %s done", (k == 0) ? "ADD" : "SUB");
    end
  endtask

  task automatic test_run_pause();
    test_fetch(4'b0001);
    @(negedge clk);
    n_assert++; if (ctrl !== 12'h240) begin n_fail++; $display("FAIL pause_t4_ctrl got %h expected 240", ctrl); end
    @(negedge clk);
    n_assert++; if (ctrl !== 12'h102) begin n_fail++; $display("FAIL pause_t5_ctrl got %h expected 102", ctrl); end
    run = 1'b0;
    #1;
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL pause_drop_ctrl got %h expected 000", ctrl); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++; if (t_state !== 6'b010000) begin n_fail++; $display("FAIL pause_t_state cyc %0d got %b expected 010000", i, t_state); end
      n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL pause_ctrl cyc %0d got %h expected 000", i, ctrl); end
      n_assert++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL pause_instr_done cyc %0d got %b expected 0", i, instr_done); end
    end
    run = 1'b1;
    #1;
    n_assert++; if (ctrl !== 12'h102) begin n_fail++; $display("FAIL resume_ctrl got %h expected 102", ctrl); end
    n_assert++; if (t_state !== 6'b010000) begin n_fail++; $display("FAIL resume_t_state got %b expected 010000", t_state); end
    @(negedge clk);
    n_assert++; if (t_state !== 6'b100000) begin n_fail++; $display("FAIL resume_t6_t_state got %b expected 100000", t_state); end
    n_assert++; if (ctrl !== 12'h024) begin n_fail++; $display("FAIL resume_t6_ctrl got %h expected 024", ctrl); end
    n_assert++; if (instr_done !== 1'b1) begin n_fail++; $display("FAIL resume_instr_done got %b expected 1", instr_done); end
    $display("test_run_pause done");
  endtask

  task automatic test_nop();
    test_fetch(4'b0101);
    for (int i = 0; i < 3; i++) begin
      logic [5:0] exp_t;
      exp_t = 6'b001000 << i;
      @(negedge clk);
      n_assert++; if (t_state !== exp_t) begin n_fail++; $display("FAIL nop_t_state step %0d got %b expected %b", i, t_state, exp_t); end
      n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL nop_ctrl step %0d got %h expected 000", i, ctrl); end
      n_assert++; if (instr_done !== (i == 2)) begin n_fail++; $display("FAIL nop_instr_done step %0d got %b expected %b", i, instr_done, (i == 2)); end
    end
    $display("test_nop done");
  endtask

  task automatic test_out_hlt();
    logic [11:0] exp_c [3] = '{12'h011, 12'h000, 12'h000};
    test_fetch(4'b1110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++; if (ctrl !== exp_c[i]) begin n_fail++; $display("FAIL out_ctrl step %0d got %h expected %h", i, ctrl, exp_c[i]); end
    end
    test_fetch(4'b1111);
    @(negedge clk);
    n_assert++; if (t_state !== 6'b001000) begin n_fail++; $display("FAIL hlt_t4_t_state got %b expected 001000", t_state); end
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL hlt_t4_ctrl got %h expected 000", ctrl); end
    n_assert++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hlt_t4_halted got %b expected 0", halted); end
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      n_assert++; if (t_state !== 6'b001000) begin n_fail++; $display("FAIL hlt_hold_t_state cyc %0d got %b expected 001000", i, t_state); end
      n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL hlt_hold_ctrl cyc %0d got %h expected 000", i, ctrl); end
      n_assert++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_hold_halted cyc %0d got %b expected 1", i, halted); end
      n_assert++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL hlt_hold_instr_done cyc %0d got %b expected 0", i, instr_done); end
      if (i == 10) opcode = 4'b0001;
    end
    $display("test_out_hlt done");
  endtask

  task automatic test_reset_mid();
    // while halted, reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (t_state !== 6'b000000) begin n_fail++; $display("FAIL rst_halt_t_state got %b expected 000000", t_state); end
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL rst_halt_ctrl got %h expected 000", ctrl); end
    n_assert++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halt_halted got %b expected 0", halted); end
    @(negedge clk);
    rst_n = 1'b1;
    test_fetch(4'b0001);
    @(negedge clk);
    n_assert++; if (ctrl !== 12'h240) begin n_fail++; $display("FAIL rst_mid_t4_ctrl got %h expected 240", ctrl); end
    @(negedge clk);
    n_assert++; if (t_state !== 6'b010000) begin n_fail++; $display("FAIL rst_mid_t5_t_state got %b expected 010000", t_state); end
    // reset mid-cycle in T5
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (t_state !== 6'b000000) begin n_fail++; $display("FAIL rst_t5_t_state got %b expected 000000", t_state); end
    n_assert++; if (ctrl !== 12'h000) begin n_fail++; $display("FAIL rst_t5_ctrl got %h expected 000", ctrl); end
    n_assert++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_t5_halted got %b expected 0", halted); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++; if (t_state !== 6'b000001) begin n_fail++; $display("FAIL rst_t5_release_t_state got %b expected 000001", t_state); end
    n_assert++; if (ctrl !== 12'h600) begin n_fail++; $display("FAIL rst_t5_release_ctrl got %h expected 600", ctrl); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_run_pause();
    test_nop();
    test_out_hlt();
    test_reset_mid();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
